// File: rtl/btn_debounce_array_if.sv
// Signal bundle between a button-debounce array and its user: raw inputs,
// repeat enables, debounced levels, per-channel event pulses and key summary.
interface btn_debounce_array_if #(
    parameter int CH_NUM = 5
);
    logic [CH_NUM-1:0] btn_raw;
    logic [CH_NUM-1:0] repeat_en;
    logic [CH_NUM-1:0] btn_level;
    logic [CH_NUM-1:0] press_pulse;
    logic [CH_NUM-1:0] release_pulse;
    logic [CH_NUM-1:0] long_pulse;
    logic [CH_NUM-1:0] repeat_pulse;
    logic              key_valid;
    logic [3:0]        key_code;

    modport master (
        output btn_raw, repeat_en,
        input  btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse,
        input  key_valid, key_code
    );

    modport slave (
        input  btn_raw, repeat_en,
        output btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse,
        output key_valid, key_code
    );
endinterface

// File: rtl/btn_debounce_array.sv
// Array of independent button channels: 2-FF sync, stable-count debounce and a
// RELEASED/PRESSED/HELD machine emitting press, release, long and repeat pulses.
module btn_debounce_array #(
    parameter int CH_NUM       = 5,
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int LONG_CNT     = 100_000_000,
    parameter int REPEAT_CNT   = 20_000_000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    btn_debounce_array_if.slave  io
);
    localparam logic INACTIVE = ACTIVE_LOW;
    localparam int   DW       = $clog2(DEBOUNCE_CNT);
    localparam int   LW       = $clog2(LONG_CNT);
    localparam int   RW       = $clog2(REPEAT_CNT);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    logic [CH_NUM-1:0] level_vec;
    logic [CH_NUM-1:0] press_vec;
    logic [CH_NUM-1:0] release_vec;
    logic [CH_NUM-1:0] long_vec;
    logic [CH_NUM-1:0] repeat_vec;

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        logic          sync1_q, sync2_q;
        logic          stable_q, stable_d;
        logic [DW-1:0] db_cnt_q, db_cnt_d;
        logic [LW-1:0] hold_cnt_q, hold_cnt_d;
        logic [RW-1:0] rep_cnt_q, rep_cnt_d;
        state_t        state_q, state_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          long_q, long_d;
        logic          repeat_q, repeat_d;
        logic          pressed;

        // Stable level stays in raw polarity; pressed is the polarity-free view.
        assign pressed = stable_q ^ INACTIVE;

        always_comb begin
            stable_d = stable_q;
            db_cnt_d = '0;
            if (sync2_q != stable_q) begin
                if (db_cnt_q == DW'(DEBOUNCE_CNT - 1)) begin
                    stable_d = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            long_d     = 1'b0;
            repeat_d   = 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    if (pressed) begin
                        state_d    = ST_PRESSED;
                        press_d    = 1'b1;
                        hold_cnt_d = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!pressed) begin
                        state_d    = ST_RELEASED;
                        release_d  = 1'b1;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end else if (hold_cnt_q == LW'(LONG_CNT - 1)) begin
                        state_d   = ST_HELD;
                        long_d    = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    // Release wins over a coincident repeat so only one pulse fires.
                    if (!pressed) begin
                        state_d    = ST_RELEASED;
                        release_d  = 1'b1;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end else if (!io.repeat_en[gi]) begin
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == RW'(REPEAT_CNT - 1)) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_RELEASED;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q    <= INACTIVE;
                sync2_q    <= INACTIVE;
                stable_q   <= INACTIVE;
                db_cnt_q   <= '0;
                state_q    <= ST_RELEASED;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
                repeat_q   <= 1'b0;
            end else begin
                sync1_q    <= io.btn_raw[gi];
                sync2_q    <= sync1_q;
                stable_q   <= stable_d;
                db_cnt_q   <= db_cnt_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
                press_q    <= press_d;
                release_q  <= release_d;
                long_q     <= long_d;
                repeat_q   <= repeat_d;
            end
        end

        assign level_vec[gi]   = (state_q != ST_RELEASED);
        assign press_vec[gi]   = press_q;
        assign release_vec[gi] = release_q;
        assign long_vec[gi]    = long_q;
        assign repeat_vec[gi]  = repeat_q;
    end

    logic [3:0] key_code;

    // Scan downward so the lowest pressed index is the last one written.
    always_comb begin
        key_code = 4'd0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (press_vec[i]) begin
                key_code = 4'(i);
            end
        end
    end

    assign io.btn_level     = level_vec;
    assign io.press_pulse   = press_vec;
    assign io.release_pulse = release_vec;
    assign io.long_pulse    = long_vec;
    assign io.repeat_pulse  = repeat_vec;
    assign io.key_valid     = |press_vec;
    assign io.key_code      = key_code;
endmodule
